// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between two requesters,
// with lock-based bursts bounded by MAX_BURST and registered per-requester read capture.
module dmem_arbiter #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read_en,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               last_owner_q, last_owner_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic               rvalid0_q, rvalid0_d;
    logic               rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0]  rdata0_q, rdata0_d;
    logic [DATA_W-1:0]  rdata1_q, rdata1_d;
    logic               acc0_c, acc1_c;

    assign gnt0    = (state_q == OWN0);
    assign gnt1    = (state_q == OWN1);
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

    // An access completes whenever the current owner is still requesting.
    assign acc0_c = (state_q == OWN0) && req0;
    assign acc1_c = (state_q == OWN1) && req1;

    // Memory pin mux, decoded straight from the state register so reset idles the bus at once.
    always_comb begin
        mem_addr       = '0;
        mem_write_data = '0;
        mem_write_en   = 1'b0;
        mem_read_en    = 1'b0;
        case (state_q)
            OWN0: begin
                mem_addr       = addr0;
                mem_write_data = wdata0;
                mem_write_en   = req0 && we0;
                mem_read_en    = req0 && !we0;
            end
            OWN1: begin
                mem_addr       = addr1;
                mem_write_data = wdata1;
                mem_write_en   = req1 && we1;
                mem_read_en    = req1 && !we1;
            end
            default: ;
        endcase
    end

    // Next-state, round-robin bookkeeping, burst counting and read capture.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        rvalid0_d    = acc0_c && !we0;
        rvalid1_d    = acc1_c && !we1;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = last_owner_q ? OWN0 : OWN1;
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (req0 && lock0 && (!req1 || (burst_cnt_q < CNT_MAX))) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end else if (req0) begin
                    state_d = OWN0;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN1: begin
                if (req1 && lock1 && (!req0 || (burst_cnt_q < CNT_MAX))) begin
                    state_d = OWN1;
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (acc0_c) begin
            last_owner_d = 1'b0;
        end else if (acc1_c) begin
            last_owner_d = 1'b1;
        end

        // Tenure length saturates; any owner change or return to IDLE restarts it.
        if ((state_d != state_q) || (state_d == IDLE)) begin
            burst_cnt_d = '0;
        end else if ((acc0_c || acc1_c) && (burst_cnt_q < CNT_MAX)) begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end

        if (rvalid0_d) begin
            rdata0_d = mem_read_data;
        end
        if (rvalid1_d) begin
            rdata1_d = mem_read_data;
        end
    end

    // State and capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table plus hand-written lock/reset sequences.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic [15:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_write_en, mem_read_en;

    logic [15:0] mem [0:255];

    int errors = 0;
    int checks = 0;

    dmem_arbiter #(.DATA_W(16), .ADDR_W(16), .MAX_BURST(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0           (req0),
        .req1           (req1),
        .we0            (we0),
        .we1            (we1),
        .addr0          (addr0),
        .addr1          (addr1),
        .wdata0         (wdata0),
        .wdata1         (wdata1),
        .lock0          (lock0),
        .lock1          (lock1),
        .gnt0           (gnt0),
        .gnt1           (gnt1),
        .rvalid0        (rvalid0),
        .rvalid1        (rvalid1),
        .rdata0         (rdata0),
        .rdata1         (rdata1),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_write_en   (mem_write_en),
        .mem_read_en    (mem_read_en),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory model: combinational read, write on the rising edge.
    assign mem_read_data = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr[7:0]] <= mem_write_data;
    end

    // in*: {req, we, lock}; ctl: {gnt0, gnt1, mem_write_en, mem_read_en}; v: {rvalid0, rvalid1}
    typedef struct packed {
        logic [2:0]  in0;
        logic [15:0] a0;
        logic [15:0] d0;
        logic [2:0]  in1;
        logic [15:0] a1;
        logic [15:0] d1;
        logic [3:0]  ctl;
        logic [15:0] maddr;
        logic [1:0]  v;
        logic [15:0] rd0;
        logic [15:0] rd1;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] i0, input logic [15:0] a0, input logic [15:0] d0,
                         input logic [2:0] i1, input logic [15:0] a1, input logic [15:0] d1);
        {req0, we0, lock0} = i0;
        addr0 = a0;
        wdata0 = d0;
        {req1, we1, lock1} = i1;
        addr1 = a1;
        wdata1 = d1;
    endtask

    initial begin
        logic [53:0] act, exp;

        tbl[0]  = '{3'b000, 16'h0000, 16'h0, 3'b000, 16'h0000, 16'h0,    4'b0000, 16'h0000, 2'b00, 16'h0000, 16'h0000};
        tbl[1]  = '{3'b100, 16'h0010, 16'h0, 3'b000, 16'h0000, 16'h0,    4'b0000, 16'h0000, 2'b00, 16'h0000, 16'h0000};
        tbl[2]  = '{3'b100, 16'h0010, 16'h0, 3'b000, 16'h0000, 16'h0,    4'b1001, 16'h0010, 2'b00, 16'h0000, 16'h0000};
        tbl[3]  = '{3'b000, 16'h0010, 16'h0, 3'b000, 16'h0000, 16'h0,    4'b1000, 16'h0010, 2'b10, 16'h1234, 16'h0000};
        tbl[4]  = '{3'b000, 16'h0010, 16'h0, 3'b110, 16'h0020, 16'hBEEF, 4'b0000, 16'h0000, 2'b00, 16'h1234, 16'h0000};
        tbl[5]  = '{3'b000, 16'h0010, 16'h0, 3'b110, 16'h0020, 16'hBEEF, 4'b0110, 16'h0020, 2'b00, 16'h1234, 16'h0000};
        tbl[6]  = '{3'b000, 16'h0010, 16'h0, 3'b100, 16'h0020, 16'hBEEF, 4'b0101, 16'h0020, 2'b00, 16'h1234, 16'h0000};
        tbl[7]  = '{3'b000, 16'h0010, 16'h0, 3'b000, 16'h0020, 16'hBEEF, 4'b0100, 16'h0020, 2'b01, 16'h1234, 16'hBEEF};
        tbl[8]  = '{3'b100, 16'h0010, 16'h0, 3'b100, 16'h0020, 16'h0,    4'b0000, 16'h0000, 2'b00, 16'h1234, 16'hBEEF};
        tbl[9]  = '{3'b100, 16'h0010, 16'h0, 3'b100, 16'h0020, 16'h0,    4'b1001, 16'h0010, 2'b00, 16'h1234, 16'hBEEF};
        tbl[10] = '{3'b100, 16'h0010, 16'h0, 3'b100, 16'h0020, 16'h0,    4'b0101, 16'h0020, 2'b10, 16'h1234, 16'hBEEF};
        tbl[11] = '{3'b100, 16'h0010, 16'h0, 3'b100, 16'h0020, 16'h0,    4'b1001, 16'h0010, 2'b01, 16'h1234, 16'hBEEF};
        tbl[12] = '{3'b000, 16'h0010, 16'h0, 3'b000, 16'h0020, 16'h0,    4'b0100, 16'h0020, 2'b10, 16'h1234, 16'hBEEF};
        tbl[13] = '{3'b100, 16'h0010, 16'h0, 3'b101, 16'h0020, 16'h0,    4'b0000, 16'h0000, 2'b00, 16'h1234, 16'hBEEF};
        tbl[14] = '{3'b100, 16'h0010, 16'h0, 3'b101, 16'h0020, 16'h0,    4'b0101, 16'h0020, 2'b00, 16'h1234, 16'hBEEF};
        tbl[15] = '{3'b100, 16'h0010, 16'h0, 3'b101, 16'h0020, 16'h0,    4'b0101, 16'h0020, 2'b01, 16'h1234, 16'hBEEF};
        tbl[16] = '{3'b100, 16'h0010, 16'h0, 3'b101, 16'h0020, 16'h0,    4'b0101, 16'h0020, 2'b01, 16'h1234, 16'hBEEF};
        tbl[17] = '{3'b100, 16'h0010, 16'h0, 3'b101, 16'h0020, 16'h0,    4'b0101, 16'h0020, 2'b01, 16'h1234, 16'hBEEF};
        tbl[18] = '{3'b100, 16'h0010, 16'h0, 3'b101, 16'h0020, 16'h0,    4'b1001, 16'h0010, 2'b01, 16'h1234, 16'hBEEF};
        tbl[19] = '{3'b100, 16'h0010, 16'h0, 3'b101, 16'h0020, 16'h0,    4'b0101, 16'h0020, 2'b10, 16'h1234, 16'hBEEF};
        tbl[20] = '{3'b000, 16'h0010, 16'h0, 3'b101, 16'h0020, 16'h0,    4'b0101, 16'h0020, 2'b01, 16'h1234, 16'hBEEF};
        tbl[21] = '{3'b000, 16'h0010, 16'h0, 3'b101, 16'h0020, 16'h0,    4'b0101, 16'h0020, 2'b01, 16'h1234, 16'hBEEF};
        tbl[22] = '{3'b000, 16'h0010, 16'h0, 3'b101, 16'h0020, 16'h0,    4'b0101, 16'h0020, 2'b01, 16'h1234, 16'hBEEF};
        tbl[23] = '{3'b000, 16'h0010, 16'h0, 3'b101, 16'h0020, 16'h0,    4'b0101, 16'h0020, 2'b01, 16'h1234, 16'hBEEF};
        tbl[24] = '{3'b000, 16'h0010, 16'h0, 3'b101, 16'h0020, 16'h0,    4'b0101, 16'h0020, 2'b01, 16'h1234, 16'hBEEF};
        tbl[25] = '{3'b000, 16'h0010, 16'h0, 3'b000, 16'h0020, 16'h0,    4'b0100, 16'h0020, 2'b01, 16'h1234, 16'hBEEF};
        tbl[26] = '{3'b000, 16'h0010, 16'h0, 3'b000, 16'h0020, 16'h0,    4'b0000, 16'h0000, 2'b00, 16'h1234, 16'hBEEF};

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h10] = 16'h1234;

        drive(3'b000, 16'h0, 16'h0, 3'b000, 16'h0, 16'h0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: inputs applied after the falling edge, outputs sampled 1 time unit later.
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].in0, tbl[i].a0, tbl[i].d0, tbl[i].in1, tbl[i].a1, tbl[i].d1);
            #1;
            act = {gnt0, gnt1, mem_write_en, mem_read_en, mem_addr, rvalid0, rvalid1, rdata0, rdata1};
            exp = {tbl[i].ctl, tbl[i].maddr, tbl[i].v, tbl[i].rd0, tbl[i].rd1};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL vec%0d: got g0g1we re=%b addr=%h v=%b rd0=%h rd1=%h expected g0g1we re=%b addr=%h v=%b rd0=%h rd1=%h",
                         i, act[53:50], act[49:34], act[33:32], act[31:16], act[15:0],
                         exp[53:50], exp[49:34], exp[33:32], exp[31:16], exp[15:0]);
            end
            @(negedge clk);
        end

        // Locked write burst by requester 0 against a waiting requester 1, from reset.
        rst_n = 1'b0;
        drive(3'b111, 16'h0040, 16'hAAAA, 3'b100, 16'h0020, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check1($sformatf("lock_burst_gnt0_%0d", i), gnt0 && !gnt1 && mem_write_en, 1'b1);
        end
        @(negedge clk);
        #1;
        check1("lock_burst_handover_gnt1", gnt1 && !gnt0 && mem_read_en, 1'b1);
        checks++;
        if (mem[8'h40] !== 16'hAAAA) begin
            errors++;
            $display("FAIL burst_write_data: got %h expected aaaa", mem[8'h40]);
        end

        // Back to requester 0, then reset while its write is on the bus.
        @(negedge clk);
        #1;
        check1("pre_reset_gnt0_write", gnt0 && mem_write_en, 1'b1);
        check1("pre_reset_rvalid1", rvalid1, 1'b1);
        rst_n = 1'b0;
        #1;
        check1("reset_mem_write_en", mem_write_en, 1'b0);
        check1("reset_gnt0", gnt0, 1'b0);
        check1("reset_rvalid0", rvalid0, 1'b0);
        check1("reset_rvalid1", rvalid1, 1'b0);

        // After release both still request; requester 0 wins and gets a full fresh burst.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check1($sformatf("post_reset_gnt0_%0d", i), gnt0 && !gnt1, 1'b1);
        end
        @(negedge clk);
        #1;
        check1("post_reset_handover_gnt1", gnt1 && !gnt0, 1'b1);

        drive(3'b000, 16'h0, 16'h0, 3'b000, 16'h0, 16'h0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Grants must be mutually exclusive at every sample point.
    always @(negedge clk) begin
        if (rst_n && gnt0 && gnt1) begin
            errors++;
            checks++;
            $display("FAIL gnt_exclusive: got gnt0=1 gnt1=1 expected at most one");
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single-port data memory between requester 0 (CPU load/store stage) and requester 1 (DMA/debug loader).
- Arbitration is round-robin, with optional lock-based bursts bounded by MAX_BURST.
- Drives the memory's addr / write_data / write_en / read_en pins and captures its combinational read data into per-requester registers with a valid pulse.
- Sits between the pipeline/DMA and data memory.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, memory address width.
- MAX_BURST, 4, maximum consecutive grants to a locked owner while the other requester waits (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0 / req1  input  1  access request, held until granted.
- we0 / we1  input  1  1 = write, 0 = read; stable while req is high.
- addr0 / addr1  input  ADDR_W  access address.
- wdata0 / wdata1  input  DATA_W  write data.
- lock0 / lock1  input  1  owner requests to keep the grant for its next access.
- gnt0 / gnt1  output  1  registered grant; an access completes in every cycle where gnt_x=1 and req_x=1.
- rvalid0 / rvalid1  output  1  one-cycle pulse, read data valid.
- rdata0 / rdata1  output  DATA_W  captured read data, held until the next read completes.
- mem_addr  output  ADDR_W  to memory addr.
- mem_write_data  output  DATA_W  to memory write_data.
- mem_write_en  output  1  to memory write_en.
- mem_read_en  output  1  to memory read_en.
- mem_read_data  input  DATA_W  from memory read_data (combinational).

Behaviour:
- **FSM states:** IDLE, OWN0, OWN1 (registered). gnt0 = (state==OWN0); gnt1 = (state==OWN1). Grants are never both 1.
- **Reset values:** state IDLE, last_owner=1 (requester 0 wins the first tie), burst_cnt=0, gnt*=0, rvalid*=0, rdata*=0.
- **Memory mux:**
  - In OWNx: mem_addr=addr_x, mem_write_data=wdata_x, mem_write_en=req_x&we_x, mem_read_en=req_x&~we_x.
  - In IDLE: all mem outputs 0.
  - The mux is combinational from state, so asserting rst_n low drops mem_write_en immediately.
- **IDLE transitions:**
  - Only one req: go to that OWN.
  - Both req: go to OWN of ~last_owner.
  - None: stay in IDLE.
  - Grant latency from IDLE is 1 cycle.
- **Accepted access:** on a cycle with gnt_x&req_x, set last_owner←x.
  - burst_cnt←burst_cnt+1 if staying in OWNx, else 0.
- **OWNx transitions** (evaluated every cycle; y = the other requester):
  - req_x & lock_x & (~req_y | burst_cnt < MAX_BURST−1): stay in OWNx.
  - else req_y: go to OWNy. Switching costs no idle cycle, so back-to-back accesses alternate.
  - else req_x: stay in OWNx (no contention, unlimited).
  - else: go to IDLE.
- **Burst counting:** burst_cnt counts completed accesses in the current tenure and saturates at MAX_BURST−1. It clears on owner change or IDLE.
- **Read capture:** on a cycle with gnt_x&req_x&~we_x, rdata_x←mem_read_data and rvalid_x←1 at the next edge. rvalid_x is 0 otherwise.
- **Write capture:** writes produce no rvalid.
- **Dropped request:** if gnt_x=1 but req_x=0 (requester withdrew), no memory access occurs and the FSM follows the transitions above.
- **Mid-burst reset:** async reset mid-burst returns to IDLE. Requests still high after reset are re-arbitrated with requester 0 winning the tie.
- **Requester rules:** requesters must not change addr/we/wdata while req is high and ungranted. The arbiter does not check this.

Test Plan:
- **Single read:** mem[0x0010]=0x1234 preloaded; req0=1, we0=0, addr0=0x0010 from IDLE -> gnt0=1 the next cycle with mem_read_en=1, mem_addr=0x0010; rvalid0 pulses the cycle after with rdata0=0x1234.
- **Write then read:** req1 writes 0xBEEF to 0x0020, then reads 0x0020 -> mem_write_en high for exactly one granted cycle; rvalid1 then shows rdata1=0xBEEF.
- **Contention fairness:** req0=req1=1 continuously, no locks, starting from reset -> grant order 0,1,0,1,… with one access per grant and gnt never both high.
- **Locked burst, MAX_BURST=4:** req0+lock0 held, req1 raised at the same time -> four consecutive OWN0 accesses, then OWN1.
- **Locked, no contention:** req1 low -> requester 0 keeps the grant indefinitely.
- **Reset mid-burst:** rst_n asserted while OWN0 performs a write -> mem_write_en, gnt0, rvalid0 go to 0 asynchronously. After release with both requests high, the first grant is gnt0 and burst_cnt=0.
